// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter family
package arb_pkg;

    // Occupancy of the 2-entry output skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // output reg empty, skid empty
        ONE   = 2'd1,  // output reg holds an entry, skid empty
        FULL  = 2'd2   // output reg and skid both hold entries
    } skid_state_t;

    // Widest one-hot vector the index helper handles.
    localparam int OH_MAX = 32;

    // Index width for n requesters; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR-reduction of the set bit positions: exact for one-hot input,
    // zero for an all-zero vector.
    function automatic logic [4:0] onehot_to_idx(input logic [OH_MAX-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int k = 0; k < OH_MAX; k++) begin
            if (oh[k]) begin
                idx = idx | 5'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_grant_mux_if.sv
// rtl/arb_grant_mux_if.sv - request/grant in, valid/ready out bundle for arb_grant_mux
interface arb_grant_mux_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
);
    import arb_pkg::*;

    localparam int IW = idx_w(N);

    logic [N-1:0]    i_req;        // per-requester valid
    logic [N*DW-1:0] i_data;       // packed payloads, requester k at [k*DW +: DW]
    logic [N-1:0]    i_grant;      // arbiter grant, one-hot or zero
    logic [N-1:0]    o_ack;        // combinational pop strobe
    logic            o_valid;      // output payload valid
    logic [DW-1:0]   o_data;       // output payload
    logic [IW-1:0]   o_src;        // source index of o_data
    logic            i_ready;      // downstream ready
    logic            o_err;        // multi-hot grant seen last cycle
    logic [CW-1:0]   o_waste_cnt;  // saturating wasted-grant count

    // Requester/arbiter/downstream side.
    modport master (
        output i_req, i_data, i_grant, i_ready,
        input  o_ack, o_valid, o_data, o_src, o_err, o_waste_cnt
    );

    // Grant mux side.
    modport slave (
        input  i_req, i_data, i_grant, i_ready,
        output o_ack, o_valid, o_data, o_src, o_err, o_waste_cnt
    );

endinterface

// File: rtl/arb_skid_buf.sv
// rtl/arb_skid_buf.sv - generic 2-entry valid/ready skid buffer with registered output
module arb_skid_buf
    import arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         areset,    // asynchronous, active-high
    input  logic         s_tvalid,  // upstream entry offered
    input  logic [W-1:0] s_tdata,
    output logic         s_tready,  // space available (not FULL)
    output logic         m_tvalid,  // registered output valid
    output logic [W-1:0] m_tdata,   // registered output entry
    input  logic         m_tready
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         out_valid_q, out_valid_d;
    logic         push;
    logic         pop;

    assign s_tready = (state_q != FULL);
    assign push     = s_tvalid & s_tready;
    assign pop      = out_valid_q & m_tready;
    assign m_tvalid = out_valid_q;
    assign m_tdata  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    out_d   = s_tdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Output drains and refills in the same cycle: no bubble.
                    out_d = s_tdata;
                end else if (push) begin
                    skid_d  = s_tdata;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_tready is low here, so only the drain path exists.
                if (pop) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: rtl/arb_grant_mux.sv
// rtl/arb_grant_mux.sv - grant-driven payload select, source pop and skid-buffered output
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter int N  = 4,   // requesters, N >= 2, N <= 32
    parameter int DW = 32,  // payload width
    parameter int CW = 16   // wasted-grant counter width
) (
    input  logic            clk,
    input  logic            areset,  // asynchronous, active-high
    arb_grant_mux_if.slave  bus      // request/grant in, valid/ready out
);

    localparam int IW = idx_w(N);
    localparam int W  = DW + IW;

    logic [N-1:0]  hit;
    logic          multi;
    logic          space;
    logic          accept;
    logic [IW-1:0] hit_idx;
    logic [W-1:0]  entry;
    logic [W-1:0]  out_entry;
    logic          out_valid;
    logic          err_q, err_d;
    logic [CW-1:0] waste_q, waste_d;

    assign hit = bus.i_grant & bus.i_req;
    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign multi  = |(bus.i_grant & (bus.i_grant - N'(1)));
    assign accept = (|hit) & ~multi & space;

    // Gated by reset so no requester is popped while the buffer is held clear.
    assign bus.o_ack = (accept && !areset) ? hit : '0;

    assign hit_idx = IW'(onehot_to_idx(OH_MAX'(hit)));
    assign entry   = {bus.i_data[hit_idx*DW +: DW], hit_idx};

    arb_skid_buf #(
        .W (W)
    ) u_skid (
        .clk      (clk),
        .areset   (areset),
        .s_tvalid (accept),
        .s_tdata  (entry),
        .s_tready (space),
        .m_tvalid (out_valid),
        .m_tdata  (out_entry),
        .m_tready (bus.i_ready)
    );

    assign bus.o_valid     = out_valid;
    assign bus.o_data      = out_entry[W-1:IW];
    assign bus.o_src       = out_entry[IW-1:0];
    assign bus.o_err       = err_q;
    assign bus.o_waste_cnt = waste_q;

    always_comb begin
        err_d   = multi;
        waste_d = waste_q;
        // A real request was granted but could not be taken: the slot is lost.
        if ((|hit) && !accept && (waste_q != {CW{1'b1}})) begin
            waste_d = waste_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_q   <= 1'b0;
            waste_q <= '0;
        end else begin
            err_q   <= err_d;
            waste_q <= waste_d;
        end
    end

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb/tb_arb_grant_mux.sv - scoreboard bench for arb_grant_mux
module tb_arb_grant_mux;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = idx_w(N);
    localparam int EW = DW + IW;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    arb_grant_mux_if #(.N(N), .DW(DW), .CW(16)) a_if ();
    arb_grant_mux_if #(.N(N), .DW(DW), .CW(4))  b_if ();

    arb_grant_mux #(.N(N), .DW(DW), .CW(16)) dut_a (
        .clk    (clk),
        .areset (areset),
        .bus    (a_if.slave)
    );

    arb_grant_mux #(.N(N), .DW(DW), .CW(4)) dut_b (
        .clk    (clk),
        .areset (areset),
        .bus    (b_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [N*DW-1:0] mkdata(input int tag);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = {16'(tag), 16'hB000 + 16'(k)};
        return d;
    endfunction

    function automatic logic [EW-1:0] model_entry(input logic [N*DW-1:0] d, input logic [N-1:0] g);
        logic [EW-1:0] e;
        e = '0;
        for (int k = 0; k < N; k++) if (g[k]) e = {d[k*DW +: DW], IW'(k)};
        return e;
    endfunction

    // One cycle on instance a: inputs change after the edge, ack is checked mid-cycle.
    task automatic drive(input logic [N-1:0] g, input logic [N-1:0] r, input logic rdy,
                         input logic [N*DW-1:0] d, input logic [N-1:0] exp_ack, input string name);
        @(posedge clk);
        #1;
        a_if.i_grant = g;
        a_if.i_req   = r;
        a_if.i_ready = rdy;
        a_if.i_data  = d;
        @(negedge clk);
        chk(name, 64'(a_if.o_ack), 64'(exp_ack));
        if (|exp_ack) exp_q.push_back(model_entry(d, exp_ack));
    endtask

    // Output monitor: pops on every transfer, checks stability while stalled.
    initial begin
        logic          stalled;
        logic [EW-1:0] held;
        logic [EW-1:0] cur;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            cur = {a_if.o_data, a_if.o_src};
            if (areset || !a_if.o_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("stall_stable", 64'(cur), 64'(held));
                if (a_if.i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_out: got %0h expected no output", cur);
                    end else begin
                        chk("sb_out", 64'(cur), 64'(exp_q.pop_front()));
                    end
                    stalled = 1'b0;
                end else begin
                    held    = cur;
                    stalled = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]    t1_grants [10];
        logic [N*DW-1:0] d6;

        t1_grants = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};

        a_if.i_grant = 4'h1;
        a_if.i_req   = 4'h1;
        a_if.i_ready = 1'b0;
        a_if.i_data  = mkdata(1);
        b_if.i_grant = '0;
        b_if.i_req   = '0;
        b_if.i_ready = 1'b0;
        b_if.i_data  = mkdata(99);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack",   64'(a_if.o_ack), 64'(0));
        chk("rst_valid", 64'(a_if.o_valid), 64'(0));
        chk("rst_data",  64'(a_if.o_data), 64'(0));
        chk("rst_src",   64'(a_if.o_src), 64'(0));
        chk("rst_err",   64'(a_if.o_err), 64'(0));
        chk("rst_waste", 64'(a_if.o_waste_cnt), 64'(0));
        @(posedge clk);
        #1;
        areset       = 1'b0;
        a_if.i_grant = '0;
        a_if.i_req   = '0;

        // 1: weighted grant sequence at full throughput
        for (int i = 0; i < 10; i++) drive(t1_grants[i], 4'hF, 1'b1, mkdata(10 + i), t1_grants[i], "t1_ack");
        drive(4'h0, 4'hF, 1'b1, mkdata(30), 4'h0, "t1_idle_ack");
        drive(4'h0, 4'hF, 1'b1, mkdata(30), 4'h0, "t1_idle_ack");
        chk("t1_waste", 64'(a_if.o_waste_cnt), 64'(0));
        chk("t1_empty", 64'(a_if.o_valid), 64'(0));

        // 2: backpressure fills ONE then FULL, further grants wasted
        drive(4'h4, 4'hF, 1'b0, mkdata(40), 4'h4, "t2_ack_one");
        drive(4'h4, 4'hF, 1'b0, mkdata(41), 4'h4, "t2_ack_full");
        drive(4'h4, 4'hF, 1'b0, mkdata(42), 4'h0, "t2_noack0");
        chk("t2_waste1", 64'(a_if.o_waste_cnt), 64'(0));
        drive(4'h4, 4'hF, 1'b0, mkdata(42), 4'h0, "t2_noack1");
        chk("t2_waste2", 64'(a_if.o_waste_cnt), 64'(1));
        drive(4'h0, 4'hF, 1'b1, mkdata(43), 4'h0, "t2_drain0");
        chk("t2_waste3", 64'(a_if.o_waste_cnt), 64'(2));
        drive(4'h0, 4'hF, 1'b1, mkdata(43), 4'h0, "t2_drain1");
        drive(4'h0, 4'hF, 1'b1, mkdata(43), 4'h0, "t2_idle");
        chk("t2_empty", 64'(a_if.o_valid), 64'(0));

        // 3: multi-hot grant
        drive(4'b0110, 4'hF, 1'b1, mkdata(50), 4'h0, "t3_ack");
        drive(4'h0, 4'hF, 1'b1, mkdata(50), 4'h0, "t3_idle0");
        chk("t3_err_hi", 64'(a_if.o_err), 64'(1));
        chk("t3_waste",  64'(a_if.o_waste_cnt), 64'(3));
        drive(4'h0, 4'hF, 1'b1, mkdata(50), 4'h0, "t3_idle1");
        chk("t3_err_lo", 64'(a_if.o_err), 64'(0));

        // 4: grant to a non-requesting port
        drive(4'b1000, 4'b0111, 1'b1, mkdata(60), 4'h0, "t4_ack");
        drive(4'h0, 4'b0111, 1'b1, mkdata(60), 4'h0, "t4_idle");
        chk("t4_valid", 64'(a_if.o_valid), 64'(0));
        chk("t4_err",   64'(a_if.o_err), 64'(0));
        chk("t4_waste", 64'(a_if.o_waste_cnt), 64'(3));

        // 5: CW=4 instance saturates at 15
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                b_if.i_grant = 4'h1;
                b_if.i_req   = 4'h1;
            end
            @(negedge clk);
            if (i < 2)   chk("t5_ack", 64'(b_if.o_ack), 64'(1));
            if (i == 2)  chk("t5_noack", 64'(b_if.o_ack), 64'(0));
            if (i == 16) chk("t5_waste14", 64'(b_if.o_waste_cnt), 64'(14));
            if (i == 17) chk("t5_waste15", 64'(b_if.o_waste_cnt), 64'(15));
            if (i == 31) chk("t5_sat", 64'(b_if.o_waste_cnt), 64'(15));
        end
        b_if.i_grant = '0;
        b_if.i_req   = '0;

        // 6: reset while FULL, then a single clean transfer
        drive(4'h1, 4'h1, 1'b0, mkdata(70), 4'h1, "t6_fill0");
        drive(4'h1, 4'h0, 1'b0, mkdata(70), 4'h0, "t6_noreq");
        drive(4'h1, 4'h1, 1'b0, mkdata(71), 4'h1, "t6_fill1");
        @(posedge clk);
        #1;
        areset       = 1'b1;
        a_if.i_grant = '0;
        a_if.i_req   = '0;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", 64'(a_if.o_valid), 64'(0));
        chk("t6_rst_waste", 64'(a_if.o_waste_cnt), 64'(0));
        chk("t6_rst_bwaste", 64'(b_if.o_waste_cnt), 64'(0));
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("t6_no_glitch", 64'(a_if.o_valid), 64'(0));
        d6 = mkdata(72);
        d6[31:0] = 32'hA5A5_0001;
        drive(4'h1, 4'h1, 1'b1, d6, 4'h1, "t6_ack");
        drive(4'h0, 4'h0, 1'b1, d6, 4'h0, "t6_idle");
        chk("t6_valid", 64'(a_if.o_valid), 64'(1));
        chk("t6_data",  64'(a_if.o_data), 64'(32'hA5A5_0001));
        chk("t6_src",   64'(a_if.o_src), 64'(0));
        drive(4'h0, 4'h0, 1'b1, d6, 4'h0, "t6_idle2");
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
